// File: rtl/i2s_rx_frame_fifo_if.sv
// Bundle between the I2S word receiver / consumer side and the stereo frame FIFO.
// master drives words and the consumer handshake; slave is the frame FIFO.
interface i2s_rx_frame_fifo_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0]   data_i;
  logic                lr_chnl_i;
  logic                write_i;
  logic [2*DATA_W-1:0] frame_o;
  logic                valid_o;
  logic                ready_i;
  logic [ADDR_W:0]     level_o;
  logic                sync_err_o;
  logic                ovf_o;
  logic                clr_ovf_i;

  modport master (
    output data_i, lr_chnl_i, write_i, ready_i, clr_ovf_i,
    input  frame_o, valid_o, level_o, sync_err_o, ovf_o
  );

  modport slave (
    input  data_i, lr_chnl_i, write_i, ready_i, clr_ovf_i,
    output frame_o, valid_o, level_o, sync_err_o, ovf_o
  );
endinterface

// File: rtl/i2s_rx_frame_fifo.sv
// Pairs left/right I2S words into {left, right} frames and buffers them in a
// first-word-fall-through FIFO with sticky overflow and channel-sync error pulses.
//
// state  | meaning
// WAIT_L | expecting a left word; a right word here is a sync error
// WAIT_R | left word held; right completes a frame, another left replaces it
module i2s_rx_frame_fifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic                 clk_i,
  input logic                 rst_i,
  i2s_rx_frame_fifo_if.slave  bus
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int FRAME_W = 2 * DATA_W;
  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    WAIT_L = 1'b0,
    WAIT_R = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   left_q, left_d;
  logic                sync_err_q, sync_err_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic [FRAME_W-1:0]  mem_q [DEPTH];
  logic [FRAME_W-1:0]  mem_d [DEPTH];

  logic                push_req;
  logic                push_ok;
  logic                pop;
  logic                full;
  logic                drop;
  logic [FRAME_W-1:0]  frame_in;

  // pairing FSM: only write_i cycles move state or touch the held left word
  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    sync_err_d = 1'b0;
    push_req   = 1'b0;
    frame_in   = {left_q, bus.data_i};
    if (bus.write_i) begin
      case (state_q)
        WAIT_L: begin
          if (bus.lr_chnl_i) begin
            sync_err_d = 1'b1;
          end else begin
            left_d  = bus.data_i;
            state_d = WAIT_R;
          end
        end
        WAIT_R: begin
          if (bus.lr_chnl_i) begin
            push_req = 1'b1;
            state_d  = WAIT_L;
          end else begin
            left_d     = bus.data_i;
            sync_err_d = 1'b1;
          end
        end
        default: state_d = WAIT_L;
      endcase
    end
  end

  // a full FIFO still takes the new frame when the head leaves on the same edge
  always_comb begin
    pop      = (level_q != '0) && bus.ready_i;
    full     = (level_q == LEVEL_FULL);
    push_ok  = push_req && (!full || pop);
    drop     = push_req && !push_ok;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = frame_in;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
      2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    if (bus.clr_ovf_i) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= WAIT_L;
      left_q     <= '0;
      sync_err_q <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      left_q     <= left_d;
      sync_err_q <= sync_err_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // storage needs no reset: zeroed pointers make stale entries unreachable
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign bus.frame_o    = mem_q[rd_ptr_q];
  assign bus.valid_o    = (level_q != '0);
  assign bus.level_o    = level_q;
  assign bus.sync_err_o = sync_err_q;
  assign bus.ovf_o      = ovf_q;

endmodule

// File: doc/i2s_rx_frame_fifo.md
Name: i2s_rx_frame_fifo

Overview:
- Downstream stage of the I2S receiver. Consumes its per-word strobe, 16-bit word and channel flag.
- Pairs each left word with the following right word into one stereo frame.
- Buffers frames in a first-word-fall-through FIFO with a valid/ready output toward the DSP/bus side.
- Runs on the same clock as the receiver (the I2S bit clock) and flags channel-sync errors and overflow.

Parameters:
- DATA_W, 16, width of one channel word; frame width is 2*DATA_W.
- ADDR_W, 3, FIFO address width; depth DEPTH = 2**ADDR_W frames.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- data_i  input  DATA_W  received channel word, valid when write_i=1.
- lr_chnl_i  input  1  channel of data_i: 0 = left, 1 = right.
- write_i  input  1  one-cycle strobe, word present on data_i.
- frame_o  output  2*DATA_W  head frame, {left, right}; left in the MSBs.
- valid_o  output  1  FIFO not empty, frame_o valid.
- ready_i  input  1  consumer accepts frame_o this cycle.
- level_o  output  ADDR_W+1  frames stored, 0..DEPTH.
- sync_err_o  output  1  one-cycle pulse on an out-of-order channel word.
- ovf_o  output  1  sticky: a completed frame was dropped because the FIFO was full.
- clr_ovf_i  input  1  clears ovf_o.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - state=WAIT_L, pointers=0, level_o=0, valid_o=0, sync_err_o=0, ovf_o=0.
  - frame_o is don't-care while valid_o=0; the left-holding register is cleared to 0.
  - Reset mid-frame discards the held left word and all buffered frames.
- Pairing FSM, acting only on cycles with write_i=1:
  - WAIT_L, lr=0: hold data_i as left; go to WAIT_R.
  - WAIT_L, lr=1: discard the word; pulse sync_err_o next cycle; stay in WAIT_L.
  - WAIT_R, lr=1: form frame {left, data_i}; push request; go to WAIT_L.
  - WAIT_R, lr=0: overwrite the held left with data_i; pulse sync_err_o; stay in WAIT_R.
  - write_i=0: hold the current state.
- Push and pop:
  - A push request and any pop take effect at the same rising edge. A push writes mem[wr_ptr] and increments wr_ptr.
  - Pop = valid_o & ready_i. It increments rd_ptr; frame_o then shows the next entry.
  - ready_i while valid_o=0 has no effect.
- Latency: from the edge sampling the right-word strobe, valid_o=1 and frame_o are valid on the following cycle when the FIFO was empty (1-cycle latency).
- Full handling:
  - A push is accepted if level_o<DEPTH, or if a pop occurs the same cycle. Simultaneous push+pop at full keeps level_o=DEPTH.
  - Otherwise the frame is dropped, ovf_o is set, and FIFO contents are unchanged.
- Level accounting:
  - level_o: +1 on accepted push only, −1 on pop only, unchanged on both or neither.
  - Pointers wrap modulo DEPTH.
- ovf_o:
  - Cleared when clr_ovf_i=1.
  - If a new overflow occurs in the same cycle as clr_ovf_i, set wins and ovf_o stays 1.
- sync_err_o is registered, high exactly one cycle per offending word.
- Output timing: all outputs are registered or derive only from registered state. frame_o is a combinational read of mem[rd_ptr]; there is no combinational path from inputs to outputs.

Test Plan:
- Pairing: after reset, write L=0x1234 then R=0xABCD (16 cycles apart), ready_i=0 -> the cycle after the R strobe: valid_o=1, frame_o=0x1234ABCD, level_o=1, sync_err_o=0.
- Out-of-order words: write R=0x1111 in WAIT_L, then L=0x2222, L=0x3333, R=0x4444 -> two sync_err_o pulses (after the R word and after L=0x3333); single frame 0x33334444.
- Fill and overflow: ready_i=0, push 9 frames with DEPTH=8 -> level_o=8, ovf_o=1 after the 9th. Then drain with ready_i=1 -> frames 1..8 in order, the 9th absent, level_o returns to 0.
- Full with simultaneous pop: FIFO full, ready_i=1 on the cycle the 9th frame completes -> frame accepted, level_o stays 8, ovf_o=0. The drained order ends with the 9th frame.
- Overflow clear race: ovf_o=1; pulse clr_ovf_i alone -> ovf_o=0. Pulse clr_ovf_i in the same cycle as a new full-drop -> ovf_o=1.
- Reset mid-operation: 3 frames buffered, left word held. Assert rst_i one cycle -> level_o=0, valid_o=0, ovf_o=0. A following R word gives sync_err_o=1 and no frame.
